float_slice_sequencer: RTL and testbench

Upstream controller for the shader core's `float_mux` slice selector. Captures one WIDTH_IN-lane float vector per valid/ready handshake and holds it on the mux data input. Steps the mux select through every WIDTH_OUT-lane slice. Presents each registered mux output to the downstream lane datapath with valid/ready flow control, so the combined sequencer-plus-mux pair acts as an elastic wide-to-narrow converter.

---
 rtl/float_slice_if.sv | 29 ++
 rtl/float_slice_sequencer.sv | 81 ++++++++
 tb/tb_float_slice_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/float_slice_if.sv
// Handshake bundle between the slice sequencer, its float_mux and the downstream lane datapath.
// master: the sequencer side. slave: the environment around it.
interface float_slice_if #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 4,
  parameter int FBITS     = 18
);
  localparam int SELW = $clog2(WIDTH_IN) - $clog2(WIDTH_OUT);

  logic [WIDTH_IN-1:0][FBITS-1:0] vec_in;
  logic                           vec_valid;
  logic                           vec_ready;
  logic [WIDTH_IN-1:0][FBITS-1:0] mux_in;
  logic [SELW-1:0]                mux_sel;
  logic                           slice_valid;
  logic [SELW-1:0]                slice_idx;
  logic                           slice_last;
  logic                           slice_ready;

  modport master (
    input  vec_in, vec_valid, slice_ready,
    output vec_ready, mux_in, mux_sel, slice_valid, slice_idx, slice_last
  );

  modport slave (
    output vec_in, vec_valid, slice_ready,
    input  vec_ready, mux_in, mux_sel, slice_valid, slice_idx, slice_last
  );
endinterface

// File: rtl/float_slice_sequencer.sv
// Drives a registered float_mux so the pair behaves as an elastic wide-to-narrow converter.
// The mux output lags mux_sel by one cycle, hence the PRIME cycle after every capture.
module float_slice_sequencer #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 4,
  parameter int FBITS     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  float_slice_if.master bus
);
  localparam int RATIO = WIDTH_IN / WIDTH_OUT;
  localparam int SELW  = $clog2(WIDTH_IN) - $clog2(WIDTH_OUT);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(RATIO - 1);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("float_slice_sequencer: WIDTH_IN/WIDTH_OUT must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t                         state;
  logic [WIDTH_IN-1:0][FBITS-1:0] cap_buf;
  logic [SELW-1:0]                idx;

  logic            last;
  logic            fire;
  logic            vec_rdy;
  logic            vfire;
  logic [SELW-1:0] sel;

  always_comb begin
    last    = (state == STREAM) && (idx == LAST_IDX);
    fire    = (state == STREAM) && bus.slice_ready;
    vec_rdy = (state == IDLE) || (fire && last);
    vfire   = vec_rdy && bus.vec_valid;
    sel     = '0;
    // Advance the select in the same cycle as the fire so the next slice is registered on time.
    if (state == STREAM) sel = (fire && !last) ? idx + 1'b1 : idx;
  end

  assign bus.vec_ready   = vec_rdy;
  assign bus.mux_in      = cap_buf;
  assign bus.mux_sel     = sel;
  assign bus.slice_valid = (state == STREAM);
  assign bus.slice_idx   = idx;
  assign bus.slice_last  = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cap_buf <= '0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vfire) begin
            cap_buf <= bus.vec_in;
            idx     <= '0;
            state   <= PRIME;
          end
        end
        PRIME: state <= STREAM;
        STREAM: begin
          if (fire) begin
            if (!last) begin
              idx <= idx + 1'b1;
            end else if (vfire) begin
              cap_buf <= bus.vec_in;
              idx     <= '0;
              state   <= PRIME;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_slice_sequencer.sv
// Directed bench: sequencer plus a behavioural float_mux, default geometry and a RATIO=2 instance.
module tb_float_slice_sequencer;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  float_slice_if #(.WIDTH_IN(16), .WIDTH_OUT(4), .FBITS(18)) bus ();
  float_slice_if #(.WIDTH_IN(8),  .WIDTH_OUT(4), .FBITS(18)) bus2 ();

  float_slice_sequencer #(.WIDTH_IN(16), .WIDTH_OUT(4), .FBITS(18)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  float_slice_sequencer #(.WIDTH_IN(8), .WIDTH_OUT(4), .FBITS(18)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // Behavioural float_mux: registers the selected slice every cycle, no enable
  logic [3:0][17:0] mq;
  logic [3:0][17:0] mq2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq  <= '0;
      mq2 <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        mq[j]  <= bus.mux_in[int'(bus.mux_sel) * 4 + j];
        mq2[j] <= bus2.mux_in[int'(bus2.mux_sel) * 4 + j];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0][17:0] mkvec(input int base);
    logic [15:0][17:0] v;
    for (int k = 0; k < 16; k++) v[k] = 18'(base + k);
    return v;
  endfunction

  function automatic logic [7:0][17:0] mkvec8(input int base);
    logic [7:0][17:0] v;
    for (int k = 0; k < 8; k++) v[k] = 18'(base + k);
    return v;
  endfunction

  function automatic logic [3:0][17:0] mkslice(input int base);
    logic [3:0][17:0] s;
    for (int k = 0; k < 4; k++) s[k] = 18'(base + k);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one presented slice s of a vector whose lane k holds base+k
  task automatic chk_slice(input string tag, input int base, input int s);
    chk({tag, "_valid"}, 128'(bus.slice_valid), 128'(1));
    chk({tag, "_idx"},   128'(bus.slice_idx),   128'(s));
    chk({tag, "_last"},  128'(bus.slice_last),  128'(s == 3));
    chk({tag, "_data"},  128'(mq),              128'(mkslice(base + 4 * s)));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.vec_in = '0;  bus.vec_valid = 1'b0;  bus.slice_ready = 1'b0;
    bus2.vec_in = '0; bus2.vec_valid = 1'b0; bus2.slice_ready = 1'b1;
    #12;
    chk("rst_vec_ready",   128'(bus.vec_ready),   128'(1));
    chk("rst_slice_valid", 128'(bus.slice_valid), 128'(0));
    chk("rst_mux_sel",     128'(bus.mux_sel),     128'(0));
    chk("rst_mux_in",      128'(bus.mux_in),      128'(0));
    chk("rst_slice_idx",   128'(bus.slice_idx),   128'(0));
    chk("rst_slice_last",  128'(bus.slice_last),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.slice_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_valid", 128'(bus.slice_valid), 128'(0));
      chk("idle_ready", 128'(bus.vec_ready),   128'(1));
      chk("idle_sel",   128'(bus.mux_sel),     128'(0));
    end

    // Single vector, downstream always ready
    bus.vec_in = mkvec('h100); bus.vec_valid = 1'b1;
    tick();
    bus.vec_valid = 1'b0;
    chk("single_prime_valid", 128'(bus.slice_valid), 128'(0));
    chk("single_prime_ready", 128'(bus.vec_ready),   128'(0));
    chk("single_mux_in",      128'(bus.mux_in),      128'(mkvec('h100)));
    tick();
    for (int s = 0; s < 4; s++) begin
      chk_slice("single", 'h100, s);
      chk("single_vec_ready", 128'(bus.vec_ready), 128'(s == 3));
      tick();
    end
    chk("single_end_valid", 128'(bus.slice_valid), 128'(0));
    chk("single_end_ready", 128'(bus.vec_ready),   128'(1));

    // Back-to-back A then B with vec_valid held high
    bus.vec_in = mkvec('h200); bus.vec_valid = 1'b1;
    tick();
    bus.vec_in = mkvec('h300);
    chk("b2b_prime_ready", 128'(bus.vec_ready), 128'(0));
    tick();
    for (int s = 0; s < 4; s++) begin
      chk_slice("b2b_a", 'h200, s);
      chk("b2b_a_vec_ready", 128'(bus.vec_ready), 128'(s == 3));
      tick();
    end
    chk("b2b_bubble_valid", 128'(bus.slice_valid), 128'(0));
    chk("b2b_b_captured",   128'(bus.mux_in),      128'(mkvec('h300)));
    bus.vec_valid = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      chk_slice("b2b_b", 'h300, s);
      tick();
    end
    chk("b2b_end_valid", 128'(bus.slice_valid), 128'(0));

    // Stalls: 3 cycles on slice 1, 1 cycle on slice 3
    bus.vec_in = mkvec('h400); bus.vec_valid = 1'b1;
    tick();
    bus.vec_valid = 1'b0;
    tick();
    chk_slice("stall", 'h400, 0);
    tick();
    bus.slice_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_slice("stall_s1_hold", 'h400, 1);
      chk("stall_s1_sel",       128'(bus.mux_sel),   128'(1));
      chk("stall_s1_vec_ready", 128'(bus.vec_ready), 128'(0));
      tick();
    end
    bus.slice_ready = 1'b1;
    #1;
    chk_slice("stall_s1_go", 'h400, 1);
    chk("stall_s1_go_sel", 128'(bus.mux_sel), 128'(2));
    tick();
    chk_slice("stall", 'h400, 2);
    tick();
    bus.slice_ready = 1'b0;
    #1;
    chk_slice("stall_s3_hold", 'h400, 3);
    chk("stall_s3_vec_ready", 128'(bus.vec_ready), 128'(0));
    tick();
    bus.slice_ready = 1'b1;
    #1;
    chk_slice("stall_s3_go", 'h400, 3);
    chk("stall_s3_go_ready", 128'(bus.vec_ready), 128'(1));
    tick();
    chk("stall_end_valid", 128'(bus.slice_valid), 128'(0));

    // Reset mid-vector after slice 1 fires
    bus.vec_in = mkvec('h500); bus.vec_valid = 1'b1;
    tick();
    bus.vec_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_slice("prereset", 'h500, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid",     128'(bus.slice_valid), 128'(0));
    chk("mrst_vec_ready", 128'(bus.vec_ready),   128'(1));
    chk("mrst_mux_in",    128'(bus.mux_in),      128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle_valid", 128'(bus.slice_valid), 128'(0));
    bus.vec_in = mkvec('h600); bus.vec_valid = 1'b1;
    tick();
    bus.vec_valid = 1'b0;
    chk("mrst_prime_valid", 128'(bus.slice_valid), 128'(0));
    tick();
    for (int s = 0; s < 4; s++) begin
      chk_slice("mrst_next", 'h600, s);
      tick();
    end
    chk("mrst_end_valid", 128'(bus.slice_valid), 128'(0));

    // RATIO=2 geometry: 8 lanes into two 4-lane slices
    bus2.vec_in = mkvec8('h700); bus2.vec_valid = 1'b1;
    tick();
    bus2.vec_valid = 1'b0;
    chk("r2_prime_valid", 128'(bus2.slice_valid), 128'(0));
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("r2_valid", 128'(bus2.slice_valid), 128'(1));
      chk("r2_idx",   128'(bus2.slice_idx),   128'(s));
      chk("r2_last",  128'(bus2.slice_last),  128'(s == 1));
      chk("r2_data",  128'(mq2),              128'(mkslice('h700 + 4 * s)));
      tick();
    end
    chk("r2_end_valid", 128'(bus2.slice_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
